// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared CPU types -- machine word, ALU opcodes and the
// state encoding of the ALU operand/opcode sequencer (alu_input_seq).
package cpu_types_pkg;

   localparam int WORD_W = 32;

   typedef logic [WORD_W-1:0] word_t;

   typedef enum logic [3:0] {
      ALU_SLL  = 4'd0,
      ALU_SRL  = 4'd1,
      ALU_ADD  = 4'd2,
      ALU_SUB  = 4'd3,
      ALU_AND  = 4'd4,
      ALU_OR   = 4'd5,
      ALU_XOR  = 4'd6,
      ALU_NOR  = 4'd7,
      ALU_SLT  = 4'd10,
      ALU_SLTU = 4'd11
   } aluop_t;

   typedef enum logic [2:0] {
      LOAD_A  = 3'd0,
      LOAD_B  = 3'd1,
      LOAD_OP = 3'd2,
      EXEC    = 3'd3,
      SHOW    = 3'd4
   } alu_seq_state_t;

endpackage

// File: rtl/debounce_sync.sv
// debounce_sync: 2-flop synchronizer plus counter debouncer for one
// active-low push-button. Emits a single-cycle press_p on an accepted
// press (debounced 1->0); a release produces no pulse. Raw edge to pulse
// is DEBOUNCE_CYCLES+2 cycles.
module debounce_sync #(
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  logic CLK,
   input  logic nRST,
   input  logic raw_n,
   output logic press_p
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync1_q;
   logic             sync2_q;
   logic             deb_q;
   logic [CNT_W-1:0] cnt_q;
   logic             press_q;

   // Bring the asynchronous button level into the CLK domain.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
      end else begin
         sync1_q <= raw_n;
         sync2_q <= sync1_q;
      end
   end

   // Accept a level change only after it has been stable long enough; pulse on press.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         deb_q   <= 1'b1;
         cnt_q   <= '0;
         press_q <= 1'b0;
      end else begin
         press_q <= 1'b0;
         if (sync2_q != deb_q) begin
            if (cnt_q == CNT_LAST) begin
               deb_q   <= sync2_q;
               cnt_q   <= '0;
               press_q <= ~sync2_q;
            end else begin
               cnt_q <= cnt_q + CNT_W'(1);
            end
         end else begin
            cnt_q <= '0;
         end
      end
   end

   assign press_p = press_q;

endmodule

// File: rtl/alu_input_seq.sv
// alu_input_seq: turns debounced enter/clear presses and switch values into
// registered ALU operands A/B and opcode, pulses exec for the cycle the ALU
// result is sampled, then holds result and flags for display.
// Optional build macro ALU_SEQ_CHAIN_EN: when defined, enter in SHOW loads
// the held result into operand A and continues at LOAD_B; otherwise enter in
// SHOW simply restarts at LOAD_A with all registers untouched.
module alu_input_seq
   import cpu_types_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int IN_W            = 17
) (
   input  logic            CLK,
   input  logic            nRST,
   input  logic            enter_n,
   input  logic            clear_n,
   input  logic [IN_W-1:0] sw,
   input  word_t           alu_out,
   input  logic            alu_negative,
   input  logic            alu_zero,
   input  logic            alu_overflow,
   output word_t           porta,
   output word_t           portb,
   output aluop_t          aluop,
   output logic            exec,
   output word_t           result,
   output logic [2:0]      flags,
   output logic [2:0]      state_o,
   output logic            busy
);

   logic           enter_p;
   logic           clear_p;
   word_t          sw_sext;

   alu_seq_state_t state_q;
   word_t          porta_q;
   word_t          portb_q;
   aluop_t         aluop_q;
   word_t          result_q;
   logic [2:0]     flags_q;
   logic           exec_q;
   logic           busy_q;

   debounce_sync #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_enter_db (
      .CLK     (CLK),
      .nRST    (nRST),
      .raw_n   (enter_n),
      .press_p (enter_p)
   );

   debounce_sync #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear_db (
      .CLK     (CLK),
      .nRST    (nRST),
      .raw_n   (clear_n),
      .press_p (clear_p)
   );

   assign sw_sext = {{(32-IN_W){sw[IN_W-1]}}, sw};

   // Sequencer FSM: clear has priority; exec/busy are registered alongside the state.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q  <= LOAD_A;
         porta_q  <= '0;
         portb_q  <= '0;
         aluop_q  <= ALU_SLL;
         result_q <= '0;
         flags_q  <= 3'b000;
         exec_q   <= 1'b0;
         busy_q   <= 1'b1;
      end else begin
         exec_q <= 1'b0;
         if (clear_p) begin
            state_q  <= LOAD_A;
            porta_q  <= '0;
            portb_q  <= '0;
            aluop_q  <= ALU_SLL;
            result_q <= '0;
            flags_q  <= 3'b000;
            busy_q   <= 1'b1;
         end else begin
            case (state_q)
               LOAD_A: begin
                  if (enter_p) begin
                     porta_q <= sw_sext;
                     state_q <= LOAD_B;
                  end
               end
               LOAD_B: begin
                  if (enter_p) begin
                     portb_q <= sw_sext;
                     state_q <= LOAD_OP;
                  end
               end
               LOAD_OP: begin
                  if (enter_p) begin
                     aluop_q <= aluop_t'(sw[3:0]);
                     state_q <= EXEC;
                     exec_q  <= 1'b1;
                  end
               end
               EXEC: begin
                  result_q <= alu_out;
                  flags_q  <= {alu_overflow, alu_zero, alu_negative};
                  state_q  <= SHOW;
                  busy_q   <= 1'b0;
               end
               SHOW: begin
                  if (enter_p) begin
                     busy_q <= 1'b1;
`ifdef ALU_SEQ_CHAIN_EN
                     porta_q <= result_q;
                     state_q <= LOAD_B;
`else
                     state_q <= LOAD_A;
`endif
                  end
               end
               default: begin
                  state_q <= LOAD_A;
                  busy_q  <= 1'b1;
               end
            endcase
         end
      end
   end

   assign porta   = porta_q;
   assign portb   = portb_q;
   assign aluop   = aluop_q;
   assign exec    = exec_q;
   assign result  = result_q;
   assign flags   = flags_q;
   assign state_o = state_q;
   assign busy    = busy_q;

endmodule
